// File: rtl/usr_shift_sequencer.sv
// Sequencer for a cascade of USR4 slices: optional parallel load, then COUNT
// single-bit shifts with zero/one/arithmetic/rotate fill, with BUSY/DONE handshake.
module usr_shift_sequencer #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned CNTW  = 6
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic            LDEN,
    input  logic            DIR,
    input  logic [1:0]      MODE,
    input  logic [CNTW-1:0] COUNT,
    input  logic            ABORT,
    input  logic            QMSB,
    input  logic            QLSB,
    output logic [1:0]      SEL,
    output logic            S0,
    output logic            S3,
    output logic            BUSY,
    output logic            DONE
);

    localparam logic [1:0] SEL_LOAD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_ONE   = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;
    localparam logic [1:0] MODE_ROT   = 2'b11;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CNTW-1:0] cnt_start;

    // Rotating by more than WIDTH is meaningful, so only non-rotate counts are clamped.
    always_comb begin
        if (MODE == MODE_ROT || COUNT <= CNT_MAX) begin
            cnt_start = COUNT;
        end else begin
            cnt_start = CNT_MAX;
        end
    end

    // Next-state, command latching and registered output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    dir_d  = DIR;
                    mode_d = MODE;
                    cnt_d  = cnt_start;
                    if (LDEN) begin
                        state_d = ST_LOAD;
                    end else if (cnt_start != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        sel_d  = SEL_HOLD;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_LOAD: begin
                sel_d  = SEL_LOAD;
                busy_d = 1'b1;
            end
            ST_SHIFT: begin
                sel_d  = dir_d ? SEL_LEFT : SEL_RIGHT;
                busy_d = 1'b1;
            end
            ST_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                sel_d = SEL_HOLD;
            end
        endcase
    end

    // Serial fill at the entering end; the opposite end is held at 0.
    always_comb begin
        S0 = 1'b0;
        S3 = 1'b0;
        if (state_q == ST_SHIFT) begin
            case (mode_q)
                MODE_ZERO: begin
                    S0 = 1'b0;
                    S3 = 1'b0;
                end
                MODE_ONE: begin
                    S0 = ~dir_q;
                    S3 = dir_q;
                end
                MODE_ARITH: begin
                    S0 = dir_q ? 1'b0 : QMSB;
                end
                default: begin
                    if (dir_q) begin
                        S3 = QMSB;
                    end else begin
                        S0 = QLSB;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= MODE_ZERO;
            sel_q   <= SEL_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SEL  = sel_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer driving a single behavioural USR4 slice (WIDTH=4, D=1010).
module tb_usr_shift_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNTW  = 6;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            lden;
    logic            dir;
    logic [1:0]      mode;
    logic [CNTW-1:0] count;
    logic            abort;
    logic [1:0]      sel;
    logic            s0;
    logic            s3;
    logic            busy;
    logic            done;

    logic [0:3] q;
    logic [0:3] d_in;

    int errs   = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .START  (start),
        .LDEN   (lden),
        .DIR    (dir),
        .MODE   (mode),
        .COUNT  (count),
        .ABORT  (abort),
        .QMSB   (q[0]),
        .QLSB   (q[3]),
        .SEL    (sel),
        .S0     (s0),
        .S3     (s3),
        .BUSY   (busy),
        .DONE   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural USR4 slice; Q[0] is the MSB.
    always @(posedge clk) begin
        case (sel)
            2'b00:   q <= d_in;
            2'b01:   q <= {s0, q[0:2]};
            2'b10:   q <= {q[1:3], s3};
            default: q <= q;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_fill(input logic [1:0] m, input logic dr, input logic [0:3] qv);
        case (m)
            2'b00:   return 2'b00;
            2'b01:   return dr ? 2'b01 : 2'b10;
            2'b10:   return dr ? 2'b00 : {qv[0], 1'b0};
            default: return dr ? {1'b0, qv[0]} : {qv[3], 1'b0};
        endcase
    endfunction

    // Push the expected per-cycle output sequence, launch the command, then pop and compare.
    task automatic run_cmd(input string tag, input logic ldn, input logic dr, input logic [1:0] m,
                           input int cnt, input logic [0:3] exp_q, input int start_again);
        int   n;
        int   k;
        int   dones;
        exp_t e;
        n = (m == 2'b11) ? cnt : ((cnt > int'(WIDTH)) ? int'(WIDTH) : cnt);
        if (ldn) begin
            e.sel = 2'b00; e.busy = 1'b1; e.done = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.sel = dr ? 2'b10 : 2'b01; e.busy = 1'b1; e.done = 1'b0;
            sb.push_back(e);
        end
        e.sel = 2'b11; e.busy = 1'b0; e.done = 1'b1;
        sb.push_back(e);
        e.sel = 2'b11; e.busy = 1'b0; e.done = 1'b0;
        sb.push_back(e);

        lden  = ldn;
        dir   = dr;
        mode  = m;
        count = CNTW'(cnt);
        start = 1'b1;
        step();
        start = 1'b0;
        k     = 0;
        dones = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sel"},  8'(sel),  8'(e.sel));
            chk({tag, "_busy"}, 8'(busy), 8'(e.busy));
            chk({tag, "_done"}, 8'(done), 8'(e.done));
            if (e.sel == 2'b01 || e.sel == 2'b10) begin
                chk({tag, "_fill"}, 8'({s0, s3}), 8'(exp_fill(m, dr, q)));
            end else begin
                chk({tag, "_fill_idle"}, 8'({s0, s3}), 8'h00);
            end
            if (done === 1'b1) dones++;
            start = (k == start_again);
            k++;
            if (sb.size() > 0) step();
        end
        start = 1'b0;
        chk({tag, "_ndone"}, 8'(dones), 8'd1);
        chk({tag, "_q"}, 8'(q), 8'(exp_q));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        lden  = 1'b0;
        dir   = 1'b0;
        mode  = 2'b00;
        count = '0;
        abort = 1'b0;
        d_in  = 4'b1010;
        q     = 4'b0000;

        step();
        chk("rst_sel",  8'(sel),  8'h03);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        chk("rst_fill", 8'({s0, s3}), 8'h00);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_sel", 8'(sel), 8'h03);

        run_cmd("t1_zero_r1",    1'b1, 1'b0, 2'b00, 1, 4'b0101, -1);
        run_cmd("t2_arith_r2",   1'b1, 1'b0, 2'b10, 2, 4'b1110, -1);
        run_cmd("t3_rot_l5",     1'b1, 1'b1, 2'b11, 5, 4'b0101, -1);
        run_cmd("t4_cnt0",       1'b1, 1'b0, 2'b00, 0, 4'b1010, -1);
        run_cmd("t4_clamp7",     1'b1, 1'b0, 2'b00, 7, 4'b0000, -1);
        run_cmd("t5_restart_sh", 1'b1, 1'b0, 2'b00, 3, 4'b0001, 2);
        run_cmd("t5_restart_fin",1'b1, 1'b1, 2'b01, 1, 4'b0101, 2);
        run_cmd("t7_rot_r_nold", 1'b0, 1'b0, 2'b11, 1, 4'b1010, -1);
        run_cmd("t8_nold_cnt0",  1'b0, 1'b0, 2'b00, 0, 4'b1010, -1);
        run_cmd("t9_arith_l1",   1'b1, 1'b1, 2'b10, 1, 4'b0100, -1);
        run_cmd("t10_one_r2",    1'b1, 1'b0, 2'b01, 2, 4'b1110, -1);

        // Abort in the second shift cycle: that edge still shifts, then everything holds.
        lden = 1'b1; dir = 1'b0; mode = 2'b00; count = CNTW'(3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ab_load", 8'(sel), 8'h00);
        step();
        chk("ab_sh1", 8'(sel), 8'h01);
        step();
        chk("ab_sh2", 8'(sel), 8'h01);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_sel",  8'(sel),  8'h03);
        chk("ab_busy", 8'(busy), 8'h00);
        chk("ab_done", 8'(done), 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_nodone", 8'(done), 8'h00);
        end
        chk("ab_q", 8'(q), 8'(4'b0010));

        // Reset in the second shift cycle: outputs fall back immediately.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rs_sh2", 8'(sel), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_sel",  8'(sel),  8'h03);
        chk("rs_busy", 8'(busy), 8'h00);
        chk("rs_done", 8'(done), 8'h00);
        chk("rs_fill", 8'({s0, s3}), 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_nodone", 8'(done), 8'h00);
        end
        chk("rs_q", 8'(q), 8'(4'b0101));

        run_cmd("t11_after_rst", 1'b1, 1'b1, 2'b00, 2, 4'b1000, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
